// File: rtl/centroid_scanner.sv
// Reads the object data table one ID at a time and streams each non-empty
// object's centroid floor(x/area), floor(y/area) over a valid/ready port.
//  state   | meaning
//  IDLE    | waiting for start, obj_id parked at 0
//  ISSUE   | obj_id driven with cur_id, read-latency counter loaded
//  WAIT    | counting down the data-table read latency
//  CAPTURE | table outputs registered; empty objects skipped here
//  DIVIDE  | LOC_W-cycle restoring divide of both sums by area
//  OUTPUT  | record presented until the consumer takes it
//  FINISH  | one-cycle done pulse
module centroid_scanner #(
  parameter int LOC_W  = 32,
  parameter int ID_W   = 8,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       num_labels,
  output logic [ID_W-1:0]  obj_id,
  input  logic [LOC_W-1:0] obj_area,
  input  logic [LOC_W-1:0] obj_x,
  input  logic [LOC_W-1:0] obj_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [LOC_W-1:0] out_cx,
  output logic [LOC_W-1:0] out_cy,
  output logic             busy,
  output logic             done
);
  localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int DC_W  = (LOC_W > 1) ? $clog2(LOC_W) : 1;
  localparam int CMP_W = (ID_W > 8) ? ID_W : 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DIVIDE, OUTPUT, FINISH} state_t;

  state_t           state, state_nxt;
  logic [7:0]       n_lat;
  logic [ID_W-1:0]  cur_id, cur_id_nxt;
  logic [WC_W-1:0]  wait_cnt;
  logic [DC_W-1:0]  div_cnt;
  logic [LOC_W-1:0] area_r, dvd_x, dvd_y, dvd_x_nxt, dvd_y_nxt;
  logic [LOC_W:0]   rem_x, rem_y, rem_x_nxt, rem_y_nxt, trial_x, trial_y;
  logic             ge_x, ge_y, last_id;

  assign last_id = (CMP_W'(cur_id) == CMP_W'(n_lat));

  // One restoring step per cycle; the dividend register doubles as the quotient
  always_comb begin
    trial_x   = {rem_x[LOC_W-1:0], dvd_x[LOC_W-1]};
    trial_y   = {rem_y[LOC_W-1:0], dvd_y[LOC_W-1]};
    ge_x      = rem_x[LOC_W] | (trial_x >= {1'b0, area_r});
    ge_y      = rem_y[LOC_W] | (trial_y >= {1'b0, area_r});
    rem_x_nxt = ge_x ? (trial_x - {1'b0, area_r}) : trial_x;
    rem_y_nxt = ge_y ? (trial_y - {1'b0, area_r}) : trial_y;
    dvd_x_nxt = {dvd_x[LOC_W-2:0], ge_x};
    dvd_y_nxt = {dvd_y[LOC_W-2:0], ge_y};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cur_id_nxt = cur_id;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_labels == 8'd0) begin
            state_nxt = FINISH;
          end else begin
            state_nxt  = ISSUE;
            cur_id_nxt = ID_W'(1);
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: if (wait_cnt == '0) state_nxt = CAPTURE;
      CAPTURE: begin
        if (obj_area != '0) begin
          state_nxt = DIVIDE;
        end else if (last_id) begin
          state_nxt = FINISH;
        end else begin
          state_nxt  = ISSUE;
          cur_id_nxt = cur_id + 1'b1;
        end
      end
      DIVIDE: if (div_cnt == '0) state_nxt = OUTPUT;
      OUTPUT: begin
        if (out_ready) begin
          if (last_id) begin
            state_nxt = FINISH;
          end else begin
            state_nxt  = ISSUE;
            cur_id_nxt = cur_id + 1'b1;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_lat     <= '0;
      cur_id    <= '0;
      obj_id    <= '0;
      wait_cnt  <= '0;
      div_cnt   <= '0;
      area_r    <= '0;
      dvd_x     <= '0;
      dvd_y     <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_cx    <= '0;
      out_cy    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur_id <= cur_id_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == FINISH);
      // obj_id is held from ISSUE until the next ISSUE or the end of the scan
      if (state_nxt == ISSUE) begin
        obj_id <= cur_id_nxt;
      end else if (state_nxt == IDLE || state_nxt == FINISH) begin
        obj_id <= '0;
      end
      case (state)
        IDLE:  if (start) n_lat <= num_labels;
        ISSUE: wait_cnt <= WC_W'(RD_LAT - 1);
        WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        CAPTURE: begin
          area_r  <= obj_area;
          dvd_x   <= obj_x;
          dvd_y   <= obj_y;
          rem_x   <= '0;
          rem_y   <= '0;
          div_cnt <= DC_W'(LOC_W - 1);
        end
        DIVIDE: begin
          rem_x <= rem_x_nxt;
          rem_y <= rem_y_nxt;
          dvd_x <= dvd_x_nxt;
          dvd_y <= dvd_y_nxt;
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            out_valid <= 1'b1;
            out_id    <= cur_id;
            out_cx    <= dvd_x_nxt;
            out_cy    <= dvd_y_nxt;
          end
        end
        OUTPUT:  if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/centroid_scanner.md
# centroid_scanner

Hardware reader for the object data table exposed by `top`. After a frame completes, it walks object IDs 1..`num_labels` over the `obj_id` query port. For each object it samples `obj_area`/`obj_x`/`obj_y`, divides the coordinate sums by the area, and streams one centroid record per object over a valid/ready interface. It sits beside `top` and replaces software/testbench readback of object positions.

## Interface
Parameters:
- `LOC_W`, 32, width of `obj_area`/`obj_x`/`obj_y` and of the centroid outputs.
- `ID_W`, 8, width of `obj_id` and `out_id`.
- `RD_LAT`, 2, cycles from an `obj_id` change until the data-table outputs are valid; must be ≥1.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to scan; honoured only in IDLE.
- `num_labels`  in  8  label count from `top`; sampled on an accepted `start`.
- `obj_id`  out  ID_W  data-table query index.
- `obj_area`  in  LOC_W  pixel count of the queried object.
- `obj_x`  in  LOC_W  sum of x coordinates of the queried object.
- `obj_y`  in  LOC_W  sum of y coordinates of the queried object.
- `out_valid`  out  1  centroid record available.
- `out_ready`  in  1  consumer accepts the record when high together with `out_valid`.
- `out_id`  out  ID_W  object ID of the record.
- `out_cx`  out  LOC_W  floor(`obj_x` / `obj_area`).
- `out_cy`  out  LOC_W  floor(`obj_y` / `obj_area`).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the scan completes.

## Operation
States: IDLE, ISSUE, WAIT, CAPTURE, DIVIDE, OUTPUT, FINISH.

- **IDLE**
  - `obj_id`=0, `busy`=0.
  - On `start`: latch `num_labels` into `n_lat`.
  - If `n_lat`=0, go to FINISH. Otherwise set `cur_id`=1 and go to ISSUE.
- **ISSUE**
  - Drive `obj_id`=`cur_id`.
  - Load wait counter with `RD_LAT`-1 and go to WAIT.
  - `obj_id` holds `cur_id` through WAIT and CAPTURE.
- **WAIT**
  - Decrement the counter. At 0, go to CAPTURE.
- **CAPTURE**
  - Register `obj_area`, `obj_x` and `obj_y`.
  - If area = 0 (merged or removed label), skip this object: go to next-ID logic.
  - Otherwise go to DIVIDE.
- **DIVIDE**
  - Two restoring dividers share one divisor (area) and run in parallel.
  - Each produces one quotient bit per cycle, MSB first, for exactly `LOC_W` cycles.
  - Remainders are `LOC_W`+1 bits wide. The result is floor division; no rounding.
  - Then go to OUTPUT.
- **OUTPUT**
  - `out_valid`=1; `out_id`, `out_cx` and `out_cy` are stable.
  - Hold until `out_ready`=1; the handshake completes on that edge.
  - Then go to next-ID logic.
- **Next-ID logic** (CAPTURE skip or OUTPUT handshake)
  - If `cur_id` = `n_lat`, go to FINISH.
  - Otherwise increment `cur_id` and go to ISSUE.
- **FINISH**
  - `done`=1 for one cycle, then go to IDLE.

Boundary rules:
- `start` while `busy`=1 is ignored; a scan is never restarted or queued.
- Changes to `num_labels` mid-scan have no effect; `n_lat` governs.
- `num_labels`=255 scans IDs 1..255 without wrap.
- Any ID above 255 is unreachable when `ID_W` ≥ 8.
- `reset_n` low at any time, including mid-DIVIDE or mid-OUTPUT, immediately forces IDLE.
- Reset values:
  - `obj_id`=0, `out_valid`=0, `out_id`=0, `out_cx`=0, `out_cy`=0, `busy`=0, `done`=0.
  - All internal counters and registers are 0.
- After reset, the next scan requires a fresh `start`.

## Timing
- `start` edge → first `obj_id` valid: 1 cycle (entering ISSUE).
- ISSUE entry → CAPTURE: `RD_LAT`+1 cycles.
- Per-object latency, ISSUE entry → `out_valid` high: `RD_LAT`+`LOC_W`+2 cycles. With defaults this is 36.
- Skipped object (area 0): ISSUE entry → next ISSUE in `RD_LAT`+2 cycles.
- Last handshake → `done`: 1 cycle. `busy` falls the cycle after `done`.
- Zero-label scan: `start` → `done` in 1 cycle; `done` stays high 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- In OUTPUT, `out_*` must not change while `out_valid`=1 and `out_ready`=0.

## Test plan
- Start with `num_labels`=0 → `done` pulses 1 cycle later; `out_valid` never rises; `obj_id` stays 0.
- One object: area=4, x=40, y=60, `out_ready` tied high → one record id=1, cx=10, cy=15, at 36 cycles after ISSUE; `done` follows.
- Three objects with areas 3, 0, 5 and sums (10,20), (-), (25,7) → records id=1 (3,6) and id=3 (5,1); ID 2 skipped; records emitted in ID order.
- Backpressure: hold `out_ready` low 5 cycles during OUTPUT → `out_valid` and data held stable; exactly one transfer on release.
- Pulse `start` while busy, and change `num_labels` mid-scan → no effect on record count or order.
- Assert `reset_n` low mid-DIVIDE → all outputs 0 asynchronously; after release, block is idle until a new `start`, then a full scan completes correctly.
